// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state for the sequential ALU core.
// Opcode-class helpers keep the flag-ownership rules in one place.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_RCL1 = 4'd10;
  localparam logic [3:0] OP_RCR1 = 4'd11;
  localparam logic [3:0] OP_ASR1 = 4'd12;
  localparam logic [3:0] OP_SHLN = 4'd13;
  localparam logic [3:0] OP_SHRN = 4'd14;
  localparam logic [3:0] OP_ROLN = 4'd15;

  // Flag register layout is {V,Z,R,C}.
  localparam int FLG_C = 0;
  localparam int FLG_R = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ops that own the C and V flags.
  function automatic logic is_arith(input logic [3:0] op);
    return op <= OP_DEC;
  endfunction

  // Shift-by-N ops that may take the multi-cycle path.
  function automatic logic is_multi(input logic [3:0] op);
    return op >= OP_SHLN;
  endfunction

  // Single-bit shifts/rotates that write R in one cycle.
  function automatic logic is_shift1(input logic [3:0] op);
    return (op == OP_RCL1) || (op == OP_RCR1) || (op == OP_ASR1);
  endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// Combinational arithmetic/logic/one-bit-shift unit, shared by the single-cycle
// ops and by every step of the multi-cycle shifts.
module alu_seq_datapath
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             r_in,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             v_out,
  output logic             r_out
);

  logic [WIDTH-1:0] bb;
  logic             cin;
  logic [WIDTH:0]   sum;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a value held (no latches).
  always_comb begin
    bb  = b;
    cin = 1'b0;
    case (op)
      OP_ADC:  cin = c_in;
      OP_SUB:  begin bb = ~b; cin = 1'b1; end
      OP_SBB:  begin bb = ~b; cin = c_in; end
      OP_INC:  begin bb = '0; cin = 1'b1; end
      OP_DEC:  bb = '1;
      default: ;
    endcase

    sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    c_out = sum[WIDTH];
    v_out = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    y     = sum[WIDTH-1:0];
    r_out = r_in;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_RCL1: begin y = {a[WIDTH-2:0], r_in};       r_out = a[WIDTH-1]; end
      OP_RCR1: begin y = {r_in, a[WIDTH-1:1]};       r_out = a[0];       end
      OP_ASR1: begin y = {a[WIDTH-1], a[WIDTH-1:1]}; r_out = a[0];       end
      OP_SHLN: begin y = {a[WIDTH-2:0], 1'b0};       r_out = a[WIDTH-1]; end
      OP_SHRN: begin y = {1'b0, a[WIDTH-1:1]};       r_out = a[0];       end
      OP_ROLN: y = {a[WIDTH-2:0], a[WIDTH-1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with a chained flag register, multi-cycle shift-by-N ops and
// valid/ready handshakes on both the operand and the result side.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flags_wr,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [3:0]         sop_q, sop_d;
  logic [WIDTH-1:0]   result_d;
  logic [3:0]         flags_d;
  logic               out_valid_d;

  logic [3:0]         dp_op;
  logic [WIDTH-1:0]   dp_a, dp_y;
  logic               dp_c, dp_v, dp_r;

  logic               accept;
  logic [SHAMT_W-1:0] n;
  logic               done, upd_arith, upd_r;
  logic [WIDTH-1:0]   done_y;

  assign in_ready = ~rst & (state_q == ST_IDLE) & (~out_valid | out_ready) & ~flags_wr;
  assign accept   = in_valid & in_ready;
  assign n        = b[SHAMT_W-1:0];

  // In SHIFT the datapath iterates on the captured operand, not the live inputs.
  assign dp_op = (state_q == ST_SHIFT) ? sop_q  : op;
  assign dp_a  = (state_q == ST_SHIFT) ? work_q : a;

  alu_seq_datapath #(.WIDTH(WIDTH)) u_datapath (
    .op    (dp_op),
    .a     (dp_a),
    .b     (b),
    .c_in  (flags[FLG_C]),
    .r_in  (flags[FLG_R]),
    .y     (dp_y),
    .c_out (dp_c),
    .v_out (dp_v),
    .r_out (dp_r)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    sop_d       = sop_q;
    result_d    = result;
    out_valid_d = out_valid;
    flags_d     = flags_wr ? flags_in : flags;
    done        = 1'b0;
    done_y      = dp_y;
    upd_arith   = 1'b0;
    upd_r       = 1'b0;

    if (out_valid && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multi(op) && (n != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = n;
            work_d  = a;
            sop_d   = op;
          end else begin
            done      = 1'b1;
            done_y    = is_multi(op) ? a : dp_y;
            upd_arith = is_arith(op);
            upd_r     = is_shift1(op);
          end
        end
      end
      ST_SHIFT: begin
        work_d = dp_y;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_IDLE;
          done    = 1'b1;
          upd_r   = (sop_q != OP_ROLN);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing op overrides only the flags it owns; the rest keep any
    // same-cycle context restore.
    if (done) begin
      result_d       = done_y;
      out_valid_d    = 1'b1;
      flags_d[FLG_Z] = (done_y == '0);
      flags_d[FLG_V] = upd_arith & dp_v;
      if (upd_arith) flags_d[FLG_C] = dp_c;
      if (upd_r)     flags_d[FLG_R] = dp_r;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      sop_q     <= OP_ADD;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      sop_q     <= sop_d;
      result    <= result_d;
      flags     <= flags_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8): vector table for every opcode class
// plus hand-written sequences for backpressure, throughput, flag restore and reset abort.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       flags_wr = 1'b0;
  logic [3:0] flags_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flags_wr  (flags_wr),
    .flags_in  (flags_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] pre;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] pre, input logic [3:0] o,
                     input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] res,
                     input logic [3:0] flg, input int lat);
    vec_t v;
    v.name = nm; v.pre = pre; v.op = o; v.a = aa; v.b = bb;
    v.res = res; v.flg = flg; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_wr = 1'b1;
    flags_in = f;
    @(posedge clk); #1;
    flags_wr = 1'b0;
  endtask

  // Presents an op and returns 1 time unit after the edge that accepted it.
  task automatic issue(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb);
    int guard = 0;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic seen;

    add("add_ovf",   4'b0000, OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b1000, 1);
    add("add_carry", 4'b0000, OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0101, 1);
    add("sub_brw",   4'b0000, OP_SUB,  8'h00, 8'h01, 8'hFF, 4'b0000, 1);
    add("sbb_c0",    4'b0000, OP_SBB,  8'h05, 8'h01, 8'h03, 4'b0001, 1);
    add("adc_c1",    4'b0001, OP_ADC,  8'h10, 8'h20, 8'h31, 4'b0000, 1);
    add("sbb_c1",    4'b0001, OP_SBB,  8'h10, 8'h01, 8'h0F, 4'b0001, 1);
    add("inc_wrap",  4'b0000, OP_INC,  8'hFF, 8'h00, 8'h00, 4'b0101, 1);
    add("dec_zero",  4'b0000, OP_DEC,  8'h00, 8'h00, 8'hFF, 4'b0000, 1);
    add("dec_ovf",   4'b0000, OP_DEC,  8'h80, 8'h00, 8'h7F, 4'b1001, 1);
    add("and_keep",  4'b1111, OP_AND,  8'hF0, 8'h0F, 8'h00, 4'b0111, 1);
    add("or",        4'b0001, OP_OR,   8'hA0, 8'h05, 8'hA5, 4'b0001, 1);
    add("xor_clrv",  4'b1000, OP_XOR,  8'hFF, 8'hFF, 8'h00, 4'b0100, 1);
    add("not",       4'b0010, OP_NOT,  8'h55, 8'h00, 8'hAA, 4'b0010, 1);
    add("rcl_rin",   4'b0010, OP_RCL1, 8'h80, 8'h00, 8'h01, 4'b0010, 1);
    add("rcl",       4'b0000, OP_RCL1, 8'h40, 8'h00, 8'h80, 4'b0000, 1);
    add("rcr",       4'b0010, OP_RCR1, 8'h02, 8'h00, 8'h81, 4'b0000, 1);
    add("asr",       4'b0001, OP_ASR1, 8'h81, 8'h00, 8'hC0, 4'b0011, 1);
    add("shln_n0",   4'b1010, OP_SHLN, 8'h55, 8'h00, 8'h55, 4'b0010, 1);
    add("shln_1",    4'b0000, OP_SHLN, 8'h81, 8'h01, 8'h02, 4'b0010, 2);
    add("shln_3",    4'b0000, OP_SHLN, 8'h81, 8'h03, 8'h08, 4'b0000, 4);
    add("shln_mask", 4'b0000, OP_SHLN, 8'h81, 8'h09, 8'h02, 4'b0010, 2);
    add("shln_7",    4'b0000, OP_SHLN, 8'hFF, 8'h07, 8'h80, 4'b0010, 8);
    add("shrn_2",    4'b0000, OP_SHRN, 8'h81, 8'h02, 8'h20, 4'b0000, 3);
    add("shrn_z",    4'b0000, OP_SHRN, 8'h01, 8'h01, 8'h00, 4'b0110, 2);
    add("roln_4",    4'b0011, OP_ROLN, 8'h81, 8'h04, 8'h18, 4'b0011, 5);

    // Reset state
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", {24'b0, result}, 32'h00);
    check("rst_flags", {28'b0, flags}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, in_ready}, 32'd1);

    // Table-driven vectors
    foreach (vecs[i]) begin
      set_flags(vecs[i].pre);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat);
      check({vecs[i].name, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_res"}, {24'b0, result}, {24'b0, vecs[i].res});
      check({vecs[i].name, "_flags"}, {28'b0, flags}, {28'b0, vecs[i].flg});
    end

    // Borrow chaining: SUB then SBB without a flag restore in between
    issue(OP_SUB, 8'h00, 8'h01);
    wait_out(lat);
    check("chain_sub_res", {24'b0, result}, 32'hFF);
    check("chain_sub_c", {31'b0, flags[FLG_C]}, 32'd0);
    issue(OP_SBB, 8'h05, 8'h01);
    wait_out(lat);
    check("chain_sbb_res", {24'b0, result}, 32'h03);
    check("chain_sbb_c", {31'b0, flags[FLG_C]}, 32'd1);

    // Backpressure: result held for 5 cycles, next op accepted on the handshake
    set_flags(4'b0000);
    out_ready = 1'b0;
    issue(OP_ADD, 8'h01, 8'h02);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    op = OP_INC; a = 8'h10; b = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_res", {24'b0, result}, 32'h03);
      check("bp_hold_flags", {28'b0, flags}, 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'b0, out_valid}, 32'd1);
    check("bp_next_res", {24'b0, result}, 32'h11);

    // Back-to-back single-cycle ops at one per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = OP_INC; a = 8'(i * 3); b = 8'h00;
      #1;
      check("b2b_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_res", {24'b0, result}, 32'(i * 3 + 1));
    end
    in_valid = 1'b0;

    // Flag restore coinciding with the completing shift step
    set_flags(4'b0000);
    issue(OP_SHLN, 8'h81, 8'h03);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fwr_shift_busy", {31'b0, out_valid}, 32'd0);
    flags_wr = 1'b1; flags_in = 4'b1111;
    @(posedge clk); #1;
    flags_wr = 1'b0;
    check("fwr_shift_valid", {31'b0, out_valid}, 32'd1);
    check("fwr_shift_res", {24'b0, result}, 32'h08);
    check("fwr_shift_flags", {28'b0, flags}, 32'b0001);

    // flags_wr blocks a simultaneous ADC, which then uses the restored carry
    flags_wr = 1'b1; flags_in = 4'b0001;
    op = OP_ADC; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    #1;
    check("fwr_block_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flags_wr = 1'b0;
    check("fwr_loaded", {28'b0, flags}, 32'b0001);
    check("fwr_no_out", {31'b0, out_valid}, 32'd0);
    #1;
    check("fwr_unblock_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("adc_valid", {31'b0, out_valid}, 32'd1);
    check("adc_res", {24'b0, result}, 32'h03);
    check("adc_flags", {28'b0, flags}, 32'b0000);

    // Reset pulse two cycles into a long ROLN aborts it
    set_flags(4'b0011);
    issue(OP_ROLN, 8'h12, 8'h07);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_rst_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_ready", {31'b0, in_ready}, 32'd1);
    check("abort_flags", {28'b0, flags}, 32'h0);
    check("abort_result", {24'b0, result}, 32'h00);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    check("abort_no_valid", {31'b0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
